mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS-subset datapath. It sequences the shared ALU, register file, PC/IR and data memory across several cycles per instruction.
- Decodes the IR contents and drives the ALU op code (addu 000, subu 001, or 010, lui 011, sll 100), mux selects and write strobes.
- Handles a data-memory ready handshake with timeout. Sits between the IR/ALU flags and the datapath enables.

Parameters:
- TIMEOUT_CYC, 16: maximum cycles to wait for mem_ack in a memory state. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- instr  in  32  IR contents; valid from DECODE onward
- equal  in  1  ALU equality flag (A==B)
- mem_ack  in  1  data memory ready; completes the access in the cycle it is high
- state  out  3  current state: FETCH 0, DECODE 1, EXE 2, MEM_RD 3, MEM_WR 4, WB 5, BRANCH 6, JUMP 7
- pc_wr  out  1  PC load strobe
- npc_sel  out  2  next-PC source: 00 PC+4, 01 branch target, 10 j/jal target, 11 rs (jr)
- ir_wr  out  1  IR load strobe
- aluctr  out  3  ALU operation
- alub_sel  out  2  ALU B source: 00 rt, 01 sign-extended imm16, 10 zero-extended imm16
- rf_wr  out  1  register file write strobe
- rf_wa_sel  out  2  write address: 00 rt, 01 rd, 10 $31
- rf_wd_sel  out  2  write data: 00 ALU result, 01 memory data register, 10 current PC
- mem_rd  out  1  data memory read request
- mem_wr  out  1  data memory write request
- illegal  out  1  one-cycle pulse: unrecognised instruction
- timeout  out  1  one-cycle pulse: memory access abandoned

Behaviour:
- Registered: state (3b) and wait_cnt. All outputs are combinational from state, instr, equal, mem_ack and wait_cnt.
- Reset: state=FETCH, wait_cnt=0. While reset is high, every strobe (pc_wr, ir_wr, rf_wr, mem_rd, mem_wr, illegal, timeout) is 0. aluctr, npc_sel, alub_sel, rf_wa_sel and rf_wd_sel are 0 when not used.
- Reset asserted in any state (including a memory wait) returns to FETCH on the next edge. The aborted access writes nothing.
- Decode table:
  - R-type (op 000000): addu funct 100001, subu 100011, sll 000000, jr 001000.
  - Other opcodes: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
  - All other encodings are illegal. Instruction 0x00000000 is sll $0 and is legal.
- FETCH: ir_wr=1, pc_wr=1, npc_sel=00 -> DECODE.
- DECODE: no strobes.
  - j/jal/jr -> JUMP.
  - beq -> BRANCH.
  - addu/subu/sll/ori/lui/lw/sw -> EXE.
  - illegal -> illegal=1, then FETCH.
- EXE:
  - addu: aluctr 000, alub_sel 00.
  - subu: aluctr 001, alub_sel 00.
  - sll: aluctr 100, alub_sel 00.
  - ori: aluctr 010, alub_sel 10.
  - lui: aluctr 011, alub_sel 10.
  - lw/sw: aluctr 000, alub_sel 01.
  - Next state: lw -> MEM_RD, sw -> MEM_WR, others -> WB.
- MEM_RD / MEM_WR:
  - mem_rd (resp. mem_wr)=1; aluctr 000 and alub_sel 01 held stable throughout.
  - mem_ack=1 in a cycle: MEM_RD -> WB, MEM_WR -> FETCH; wait_cnt cleared.
  - Otherwise wait_cnt increments each cycle.
  - If TIMEOUT_CYC!=0 and wait_cnt==TIMEOUT_CYC-1 with mem_ack=0: timeout=1, -> FETCH, wait_cnt cleared.
  - mem_ack on the final cycle wins over timeout.
  - mem_ack outside memory states is ignored.
- WB: rf_wr=1, then FETCH.
  - R-type: wa 01, wd 00.
  - ori/lui: wa 00, wd 00.
  - lw: wa 00, wd 01.
  - EXE selects are held during WB so the ALU result stays stable.
- BRANCH: aluctr 001, alub_sel 00. If equal=1: pc_wr=1, npc_sel=01. -> FETCH.
- JUMP: pc_wr=1, then FETCH.
  - j: npc_sel 10.
  - jal: npc_sel 10, plus rf_wr=1, wa 10, wd 10 (PC already holds jal address+4).
  - jr: npc_sel 11.
- Latency with zero-wait memory (mem_ack high in first memory cycle):
  - R-type/ori/lui: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/j/jal/jr: 3 cycles.
  - Illegal: 2 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset held 3 cycles mid-MEM_RD, then released -> state=0, strobes 0 during reset; first post-reset cycle ir_wr=1, pc_wr=1.
- instr=0x00221821 (addu $3,$1,$2) -> states 0,1,2,5,0; EXE aluctr=000, alub_sel=00; WB rf_wr=1, wa=01, wd=00.
- instr=0x8C220004 (lw), mem_ack low 2 cycles then high -> MEM_RD lasts 3 cycles with mem_rd=1, aluctr=000, alub_sel=01; WB wd=01, wa=00; 7 cycles total.
- instr=0xAC220004 (sw), mem_ack never high, TIMEOUT_CYC=16 -> 16 cycles in MEM_WR, timeout pulse on 16th, then FETCH, no rf_wr.
- instr=0x10220003 (beq): equal=1 -> pc_wr=1, npc_sel=01 in BRANCH; equal=0 -> pc_wr=0; both 3 cycles.
- instr=0x0C000010 (jal) -> JUMP pc_wr=1, npc_sel=10, rf_wr=1, wa=10, wd=10. instr=0xFC000000 -> illegal pulse in DECODE, back to FETCH.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for a MIPS-subset datapath
module mc_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        equal,
  input  logic        mem_ack,
  output logic [2:0]  state,
  output logic        pc_wr,
  output logic [1:0]  npc_sel,
  output logic        ir_wr,
  output logic [2:0]  aluctr,
  output logic [1:0]  alub_sel,
  output logic        rf_wr,
  output logic [1:0]  rf_wa_sel,
  output logic [1:0]  rf_wd_sel,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        illegal,
  output logic        timeout
);
  typedef enum logic [2:0] {FETCH, DECODE, EXE, MEM_RD, MEM_WR, WB, BRANCH, JUMP} st_t;
  localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  st_t st;
  logic [CW-1:0] wait_cnt;
  logic [5:0] op, fn;
  logic r_t, addu, subu, sll, jr, ori, lui, lw, sw, beq, j, jal, jmp, exe, mem, last, alu, run;
  assign op   = instr[31:26];
  assign fn   = instr[5:0];
  assign r_t  = op == 6'b000000;
  assign addu = r_t && fn == 6'b100001;
  assign subu = r_t && fn == 6'b100011;
  assign sll  = r_t && fn == 6'b000000;
  assign jr   = r_t && fn == 6'b001000;
  assign ori  = op == 6'b001101;
  assign lui  = op == 6'b001111;
  assign lw   = op == 6'b100011;
  assign sw   = op == 6'b101011;
  assign beq  = op == 6'b000100;
  assign j    = op == 6'b000010;
  assign jal  = op == 6'b000011;
  assign jmp  = j || jal || jr;
  assign exe  = addu || subu || sll || ori || lui || lw || sw;
  assign mem  = st == MEM_RD || st == MEM_WR;
  assign last = TIMEOUT_CYC != 0 && wait_cnt == CW'(TIMEOUT_CYC - 1);
  // ALU selects stay live from EXE through MEM/WB so the result is stable when consumed
  assign alu  = st == EXE || st == WB || mem;
  assign run  = !reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= FETCH;
      wait_cnt <= '0;
    end else begin
      case (st)
        FETCH:  st <= DECODE;
        DECODE: st <= jmp ? JUMP : beq ? BRANCH : exe ? EXE : FETCH;
        EXE:    st <= lw ? MEM_RD : sw ? MEM_WR : WB;
        MEM_RD, MEM_WR:
          if (mem_ack) begin
            st       <= st == MEM_RD ? WB : FETCH;
            wait_cnt <= '0;
          end else if (last) begin
            st       <= FETCH;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        default: st <= FETCH;
      endcase
    end
  end
  assign state     = st;
  assign pc_wr     = run && (st == FETCH || st == JUMP || (st == BRANCH && equal));
  assign npc_sel   = !run ? 2'b00 : st == JUMP ? (jr ? 2'b11 : 2'b10) : (st == BRANCH && equal) ? 2'b01 : 2'b00;
  assign ir_wr     = run && st == FETCH;
  assign aluctr    = !run ? 3'b000 : st == BRANCH ? 3'b001 : !alu ? 3'b000 :
                     subu ? 3'b001 : sll ? 3'b100 : ori ? 3'b010 : lui ? 3'b011 : 3'b000;
  assign alub_sel  = (!run || !alu) ? 2'b00 : (ori || lui) ? 2'b10 : (lw || sw) ? 2'b01 : 2'b00;
  assign rf_wr     = run && (st == WB || (st == JUMP && jal));
  assign rf_wa_sel = !run ? 2'b00 : st == WB ? (r_t ? 2'b01 : 2'b00) : (st == JUMP && jal) ? 2'b10 : 2'b00;
  assign rf_wd_sel = !run ? 2'b00 : st == WB ? (lw ? 2'b01 : 2'b00) : (st == JUMP && jal) ? 2'b10 : 2'b00;
  assign mem_rd    = run && st == MEM_RD;
  assign mem_wr    = run && st == MEM_WR;
  assign illegal   = run && st == DECODE && !jmp && !beq && !exe;
  assign timeout   = run && mem && !mem_ack && last;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed-vector bench for the multi-cycle control FSM
module tb_mc_ctrl;
  logic clk = 0, reset, equal, mem_ack;
  logic [31:0] instr;
  logic [2:0] state, aluctr;
  logic pc_wr, ir_wr, rf_wr, mem_rd, mem_wr, illegal, timeout;
  logic [1:0] npc_sel, alub_sel, rf_wa_sel, rf_wd_sel;
  logic [20:0] outs;
  int vec = 0, errs = 0;

  mc_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .equal(equal), .mem_ack(mem_ack),
    .state(state), .pc_wr(pc_wr), .npc_sel(npc_sel), .ir_wr(ir_wr), .aluctr(aluctr),
    .alub_sel(alub_sel), .rf_wr(rf_wr), .rf_wa_sel(rf_wa_sel), .rf_wd_sel(rf_wd_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;
  assign outs = {state, pc_wr, npc_sel, ir_wr, aluctr, alub_sel, rf_wr, rf_wa_sel, rf_wd_sel,
                 mem_rd, mem_wr, illegal, timeout};

  // {state,pc_wr,npc_sel,ir_wr,aluctr,alub_sel,rf_wr,wa,wd,mem_rd,mem_wr,illegal,timeout}
  function automatic logic [20:0] pk(int s, int pc, int ns, int ir, int al, int ab, int rw,
                                     int wa, int wd, int mr, int mw, int il, int to);
    return {3'(s), 1'(pc), 2'(ns), 1'(ir), 3'(al), 2'(ab), 1'(rw), 2'(wa), 2'(wd),
            1'(mr), 1'(mw), 1'(il), 1'(to)};
  endfunction

  localparam logic [31:0] LW = 32'h8C220004, SW = 32'hAC220004;

  task automatic test_reset();
    logic [20:0] e [11];
    e = '{pk(0,1,0,1,0,0,0,0,0,0,0,0,0), pk(1,0,0,0,0,0,0,0,0,0,0,0,0),
          pk(2,0,0,0,0,1,0,0,0,0,0,0,0), pk(3,0,0,0,0,1,0,0,0,1,0,0,0),
          pk(3,0,0,0,0,0,0,0,0,0,0,0,0), pk(0,0,0,0,0,0,0,0,0,0,0,0,0),
          pk(0,0,0,0,0,0,0,0,0,0,0,0,0), pk(0,1,0,1,0,0,0,0,0,0,0,0,0),
          pk(1,0,0,0,0,0,0,0,0,0,0,0,0), pk(2,0,0,0,4,0,0,0,0,0,0,0,0),
          pk(5,0,0,0,4,0,1,1,0,0,0,0,0)};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      reset = i >= 4 && i <= 6;
      instr = i < 7 ? LW : 32'h0;
      mem_ack = 0;
      #1; vec++;
      if (outs !== e[i]) begin
        errs++;
        $display("FAIL reset[%0d]: got %h expected %h", i, outs, e[i]);
      end
    end
  endtask

  task automatic test_alu(input logic [31:0] ins, input int al, input int ab, input int wa);
    logic [20:0] e [4];
    e = '{pk(0,1,0,1,0,0,0,0,0,0,0,0,0), pk(1,0,0,0,0,0,0,0,0,0,0,0,0),
          pk(2,0,0,0,al,ab,0,0,0,0,0,0,0), pk(5,0,0,0,al,ab,1,wa,0,0,0,0,0)};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      instr = ins; mem_ack = 1;
      #1; vec++;
      if (outs !== e[i]) begin
        errs++;
        $display("FAIL alu %h[%0d]: got %h expected %h", ins, i, outs, e[i]);
      end
    end
  endtask

  task automatic test_lw();
    logic [20:0] e [7];
    e = '{pk(0,1,0,1,0,0,0,0,0,0,0,0,0), pk(1,0,0,0,0,0,0,0,0,0,0,0,0),
          pk(2,0,0,0,0,1,0,0,0,0,0,0,0), pk(3,0,0,0,0,1,0,0,0,1,0,0,0),
          pk(3,0,0,0,0,1,0,0,0,1,0,0,0), pk(3,0,0,0,0,1,0,0,0,1,0,0,0),
          pk(5,0,0,0,0,1,1,0,1,0,0,0,0)};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      instr = LW; mem_ack = i == 5;
      #1; vec++;
      if (outs !== e[i]) begin
        errs++;
        $display("FAIL lw[%0d]: got %h expected %h", i, outs, e[i]);
      end
    end
  endtask

  task automatic test_sw(input int ack_at);
    int n = 3 + (ack_at < 16 ? ack_at + 1 : 16);
    logic [20:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      instr = SW; mem_ack = i - 3 == ack_at;
      e = i == 0 ? pk(0,1,0,1,0,0,0,0,0,0,0,0,0) : i == 1 ? pk(1,0,0,0,0,0,0,0,0,0,0,0,0) :
          i == 2 ? pk(2,0,0,0,0,1,0,0,0,0,0,0,0) :
          pk(4,0,0,0,0,1,0,0,0,0,1,0,(i == 18 && ack_at > 15) ? 1 : 0);
      #1; vec++;
      if (outs !== e) begin
        errs++;
        $display("FAIL sw ack%0d[%0d]: got %h expected %h", ack_at, i, outs, e);
      end
    end
  endtask

  task automatic test_branch(input bit eq);
    logic [20:0] e [3];
    e = '{pk(0,1,0,1,0,0,0,0,0,0,0,0,0), pk(1,0,0,0,0,0,0,0,0,0,0,0,0),
          pk(6,eq ? 1 : 0,eq ? 1 : 0,0,1,0,0,0,0,0,0,0,0)};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr = 32'h10220003; equal = eq; mem_ack = 0;
      #1; vec++;
      if (outs !== e[i]) begin
        errs++;
        $display("FAIL beq eq%0d[%0d]: got %h expected %h", eq, i, outs, e[i]);
      end
    end
    equal = 0;
  endtask

  task automatic test_jump(input logic [31:0] ins, input int ns, input int lk);
    logic [20:0] e [3];
    e = '{pk(0,1,0,1,0,0,0,0,0,0,0,0,0), pk(1,0,0,0,0,0,0,0,0,0,0,0,0),
          pk(7,1,ns,0,0,0,lk,lk * 2,lk * 2,0,0,0,0)};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr = ins; mem_ack = 0;
      #1; vec++;
      if (outs !== e[i]) begin
        errs++;
        $display("FAIL jump %h[%0d]: got %h expected %h", ins, i, outs, e[i]);
      end
    end
  endtask

  task automatic test_illegal(input logic [31:0] ins);
    logic [20:0] e [2];
    e = '{pk(0,1,0,1,0,0,0,0,0,0,0,0,0), pk(1,0,0,0,0,0,0,0,0,0,0,1,0)};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      instr = ins; mem_ack = 0;
      #1; vec++;
      if (outs !== e[i]) begin
        errs++;
        $display("FAIL illegal %h[%0d]: got %h expected %h", ins, i, outs, e[i]);
      end
    end
  endtask

  initial begin
    reset = 1; instr = 0; equal = 0; mem_ack = 0;
    repeat (2) @(posedge clk);
    test_reset();
    test_alu(32'h00221821, 0, 0, 1);
    test_alu(32'h34220005, 2, 2, 0);
    test_alu(32'h3C010012, 3, 2, 0);
    test_alu(32'h00221823, 1, 0, 1);
    test_lw();
    test_sw(99);
    test_sw(15);
    test_sw(0);
    test_branch(1);
    test_branch(0);
    test_jump(32'h0C000010, 2, 1);
    test_jump(32'h08000010, 2, 0);
    test_jump(32'h03E00008, 3, 0);
    test_illegal(32'hFC000000);
    test_illegal(32'h0000002A);
    test_alu(32'h00221821, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
